// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetcher: JAL opcode, FSM encoding and
// the J-type immediate decoder used by the optional JAL prediction.
package inst_fetcher_pkg;

  localparam logic [6:0] OPCODE_JAL = 7'b1101111;

  typedef enum logic [0:0] {
    StFetch,
    StFull
  } fetch_state_e;

  // Sign-extended J-type immediate in bytes.
  function automatic logic signed [31:0] j_imm(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/inst_queue.sv
// Circular instruction FIFO with push, pop and a synchronous flush.
// Storage is not reset; only the pointers and count are.
module inst_queue #(
  parameter int unsigned Width    = 49,
  parameter int unsigned DepthLog = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [Width-1:0]    wdata_i,
  output logic [Width-1:0]    rdata_o,
  output logic [DepthLog:0]   count_o,
  output logic                full_o,
  output logic                empty_o
);

  localparam int unsigned Depth = 1 << DepthLog;

  logic [Width-1:0]    mem_q [Depth];
  logic [DepthLog-1:0] wr_ptr_q, rd_ptr_q;
  logic [DepthLog:0]   count_q, count_d;

  // Occupancy update; simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + 1'b1;
    end else if (pop_i && !push_i) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointer and count registers; flush empties the queue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (DepthLog + 1)'(Depth));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher: presents the PC to the instruction cache, queues hits
// for the decoder and handles branch redirects.
// Optional feature: define IFETCH_JAL_PREDICT_EN to follow JAL targets at fetch.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH      = 17,
  parameter int unsigned            INST_WIDTH      = 32,
  parameter int unsigned            QUEUE_DEPTH_LOG = 2,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC        = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  output logic [ADDR_WIDTH-1:0] inst_cache_read_addr,
  input  logic                  inst_cache_read_done,
  input  logic [INST_WIDTH-1:0] inst_cache_read_data,
  output logic                  if_valid,
  output logic [INST_WIDTH-1:0] if_inst,
  output logic [ADDR_WIDTH-1:0] if_pc,
  input  logic                  dec_ready,
  input  logic                  br_flush,
  input  logic [ADDR_WIDTH-1:0] br_target
);

  localparam int unsigned QueueDepth = 1 << QUEUE_DEPTH_LOG;
  localparam int unsigned CountW     = QUEUE_DEPTH_LOG + 1;
  localparam int unsigned EntryW     = ADDR_WIDTH + INST_WIDTH;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d, next_pc;
  fetch_state_e          state_q, state_d;

  logic              q_push, q_pop, q_flush, q_full, q_empty;
  logic [CountW-1:0] q_count;
  logic [EntryW-1:0] q_head;

  // Flush outranks push and pop; nothing moves while rdy is low.
  assign q_flush = rdy & br_flush;
  assign q_push  = rdy & inst_cache_read_done & ~q_full & ~br_flush;
  assign q_pop   = rdy & ~q_empty & dec_ready & ~br_flush;

`ifdef IFETCH_JAL_PREDICT_EN
  logic                is_jal;
  logic signed [31:0]  jal_word_off;
  assign is_jal       = (inst_cache_read_data[6:0] == OPCODE_JAL);
  assign jal_word_off = j_imm(32'(inst_cache_read_data)) >>> 2;
  // Follow JAL targets in word units; everything else falls through.
  always_comb begin
    next_pc = pc_q + ADDR_WIDTH'(1);
    if (is_jal) next_pc = pc_q + ADDR_WIDTH'(jal_word_off);
  end
`else
  assign next_pc = pc_q + ADDR_WIDTH'(1);
`endif

  // Next PC and FSM state.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (q_flush) begin
      pc_d    = br_target;
      state_d = StFetch;
    end else if (rdy) begin
      if (q_push) pc_d = next_pc;
      unique case (state_q)
        StFetch: begin
          if (q_push && !q_pop && (q_count == CountW'(QueueDepth - 1))) state_d = StFull;
        end
        StFull: begin
          if (q_pop) state_d = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  // PC and state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      state_q <= StFetch;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  inst_queue #(
    .Width    (EntryW),
    .DepthLog (QUEUE_DEPTH_LOG)
  ) u_queue (
    .clk_i   (clk),
    .rst_ni  (rst),
    .flush_i (q_flush),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .wdata_i ({pc_q, inst_cache_read_data}),
    .rdata_o (q_head),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign inst_cache_read_addr = pc_q;
  assign if_valid = ~q_empty;
  // Head outputs read as zero when empty so reset shows a clean interface.
  assign if_inst  = if_valid ? q_head[INST_WIDTH-1:0] : '0;
  assign if_pc    = if_valid ? q_head[EntryW-1:INST_WIDTH] : '0;

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_inst_fetcher;

  localparam int AW = 17;
  localparam int IW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy, done, dec_ready, br_flush;
  logic [AW-1:0] br_target, rd_addr, if_pc;
  logic [IW-1:0] rd_data, if_inst;
  logic          if_valid;

  always #5 clk = ~clk;

  inst_fetcher dut (
    .clk                  (clk),
    .rst                  (rst),
    .rdy                  (rdy),
    .inst_cache_read_addr (rd_addr),
    .inst_cache_read_done (done),
    .inst_cache_read_data (rd_data),
    .if_valid             (if_valid),
    .if_inst              (if_inst),
    .if_pc                (if_pc),
    .dec_ready            (dec_ready),
    .br_flush             (br_flush),
    .br_target            (br_target)
  );

  // Cache contents as a pure function of address; word 0x10 holds jal x5,+16.
  function automatic logic [IW-1:0] cache_word(input logic [AW-1:0] a);
    if (a == 17'h10) return 32'h0100_02EF;
    return 32'(a) * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  assign rd_data = cache_word(rd_addr);

  // Reference model state.
  logic [AW+IW-1:0] mq[$];
  logic [AW-1:0]    m_pc;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] model_next(input logic [AW-1:0] pc, input logic [IW-1:0] inst);
`ifdef IFETCH_JAL_PREDICT_EN
    if (inst[6:0] == 7'h6F) begin
      int bytes;
      bytes = (inst[31] ? -(1 << 20) : 0) + (int'(inst[19:12]) << 12) +
              (int'(inst[20]) << 11) + (int'(inst[30:21]) << 1);
      return AW'(int'(pc) + (bytes >>> 2));
    end
`endif
    return AW'(int'(pc) + 1);
  endfunction

  task automatic compare_all(input string tag);
    check_eq({tag, ".valid"}, 64'(if_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      check_eq({tag, ".pc"}, 64'(if_pc), 64'(mq[0][AW+IW-1:IW]));
      check_eq({tag, ".inst"}, 64'(if_inst), 64'(mq[0][IW-1:0]));
    end
    check_eq({tag, ".addr"}, 64'(rd_addr), 64'(m_pc));
  endtask

  // One clock: drive at negedge, model the edge, compare at the next negedge.
  task automatic step(input logic r, input logic d, input logic dr, input logic f,
                      input logic [AW-1:0] tgt);
    logic do_push, do_pop;
    logic [IW-1:0] data;
    rdy = r; done = d; dec_ready = dr; br_flush = f; br_target = tgt;
    @(posedge clk);
    if (r) begin
      if (f) begin
        mq.delete();
        m_pc = tgt;
      end else begin
        data    = cache_word(m_pc);
        do_push = d && (mq.size() < DEPTH);
        do_pop  = dr && (mq.size() != 0);
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          mq.push_back({m_pc, data});
          m_pc = model_next(m_pc, data);
        end
      end
    end
    @(negedge clk);
    compare_all("step");
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b0; done = 1'b0; dec_ready = 1'b0; br_flush = 1'b0; br_target = '0;
    mq.delete();
    m_pc = '0;
    repeat (2) @(negedge clk);
    check_eq("reset.valid", 64'(if_valid), 64'd0);
    check_eq("reset.inst", 64'(if_inst), 64'd0);
    check_eq("reset.pc", 64'(if_pc), 64'd0);
    check_eq("reset.addr", 64'(rd_addr), 64'd0);
    rst = 1'b1;

    // Streaming hits with an always-ready decoder: if_pc 0,1,2,3...
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, '0);
      check_eq("stream.pc", 64'(if_pc), 64'(i));
    end

    // Fill with decoder stalled: four pushes, PC holds at 4.
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    check_eq("full.addr", 64'(rd_addr), 64'd4);
    check_eq("full.head", 64'(if_pc), 64'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    check_eq("full.pop_no_push", 64'(rd_addr), 64'd4);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    check_eq("full.refill", 64'(rd_addr), 64'd5);

    // Flush with full queue and simultaneous hit.
    step(1'b1, 1'b1, 1'b1, 1'b1, 17'h100);
    check_eq("flush.valid", 64'(if_valid), 64'd0);
    check_eq("flush.addr", 64'(rd_addr), 64'h100);

    // Three misses at PC 8, then a hit.
    step(1'b1, 1'b1, 1'b1, 1'b1, 17'h8);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check_eq("miss.addr", 64'(rd_addr), 64'd8);
    check_eq("miss.valid", 64'(if_valid), 64'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    check_eq("miss.hit_pc", 64'(if_pc), 64'd8);

    // rdy low ignores flush, hit and pop.
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 17'h55);
    check_eq("stall.addr", 64'(rd_addr), 64'd9);
    check_eq("stall.pc", 64'(if_pc), 64'd8);

    // JAL at 0x10 with +16 byte offset.
    step(1'b1, 1'b0, 1'b1, 1'b1, 17'h10);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
`ifdef IFETCH_JAL_PREDICT_EN
    check_eq("jal.addr", 64'(rd_addr), 64'h14);
`else
    check_eq("jal.addr", 64'(rd_addr), 64'h11);
`endif

    // PC wraps silently at the top of the address space.
    step(1'b1, 1'b0, 1'b1, 1'b1, 17'h1FFFE);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    check_eq("wrap.addr", 64'(rd_addr), 64'd2);

    // Random traffic with one asynchronous reset mid-run.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #2 rst = 1'b0;
        #1;
        mq.delete();
        m_pc = '0;
        check_eq("areset.valid", 64'(if_valid), 64'd0);
        check_eq("areset.addr", 64'(rd_addr), 64'd0);
        check_eq("areset.inst", 64'(if_inst), 64'd0);
        @(negedge clk);
        rst = 1'b1;
      end
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, AW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
